choose_nodes_controller: RTL and testbench

//  Control FSM that walks the user through choosing NUM_SEL graph node indices (ref node, destination, ...).

---
 rtl/graph_ui_pkg.sv | 62 ++++++
 rtl/choose_nodes_if.sv | 54 +++++
 rtl/node_dup_check.sv | 28 ++
 rtl/choose_nodes_controller.sv | 146 ++++++++++++++
 tb/tb_choose_nodes_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/graph_ui_pkg.sv
// Shared definitions for the node-selection UI: FSM state encodings, invalid-entry
// codes, strobe bundle and width helpers used by the controller, its interface and sub-blocks.
package graph_ui_pkg;

  typedef enum logic [3:0] {
    ST_PRE   = 4'd0,
    ST_DCH   = 4'd1,
    ST_DCH_W = 4'd2,
    ST_DPR   = 4'd3,
    ST_DPR_W = 4'd4,
    ST_LD    = 4'd5,
    ST_LD_W  = 4'd6,
    ST_JDG   = 4'd7,
    ST_DUP   = 4'd8,
    ST_STO   = 4'd9,
    ST_INV   = 4'd10,
    ST_INV_W = 4'd11,
    ST_DONE  = 4'd12,
    ST_ABT   = 4'd13
  } state_e;

  localparam logic [1:0] INV_JUDGE = 2'd0;
  localparam logic [1:0] INV_DUP   = 2'd1;

  typedef struct packed {
    logic go_reset_data;
    logic go_display_choose;
    logic go_display_prompt;
    logic ld_node_index;
    logic go_judge_valid;
    logic go_display_invalid;
    logic end_process;
    logic abort_process;
  } strobes_t;

  function automatic int sel_width(input int num_sel);
    return (num_sel > 1) ? $clog2(num_sel) : 1;
  endfunction

  function automatic int ret_width(input int max_retries);
    return ($clog2(max_retries + 1) > 1) ? $clog2(max_retries + 1) : 1;
  endfunction

  // Wait states keep the strobe of the state they belong to, so a display stays lit until release.
  function automatic strobes_t decode_strobes(input state_e s);
    strobes_t r;
    r = '0;
    case (s)
      ST_PRE:             r.go_reset_data      = 1'b1;
      ST_DCH, ST_DCH_W:   r.go_display_choose  = 1'b1;
      ST_DPR, ST_DPR_W:   r.go_display_prompt  = 1'b1;
      ST_LD, ST_LD_W:     r.ld_node_index      = 1'b1;
      ST_JDG:             r.go_judge_valid     = 1'b1;
      ST_INV, ST_INV_W:   r.go_display_invalid = 1'b1;
      ST_DONE:            r.end_process        = 1'b1;
      ST_ABT:             r.abort_process      = 1'b1;
      default:            r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/choose_nodes_if.sv
// Handshake bundle between the node-selection controller (slave) and the
// sequencer / display / judge side (master).
interface choose_nodes_if
  import graph_ui_pkg::*;
#(
  parameter int NODE_W      = 4,
  parameter int NUM_SEL     = 2,
  parameter int MAX_RETRIES = 3
);
  localparam int SEL_W = sel_width(NUM_SEL);
  localparam int RET_W = ret_width(MAX_RETRIES);

  logic                      start_process;
  logic                      go;
  logic                      input_over;
  logic                      data_reset_done;
  logic                      done_judge;
  logic                      node_index_valid;
  logic [NODE_W-1:0]         node_index_in;

  logic                      end_process;
  logic                      abort_process;
  logic                      go_reset_data;
  logic                      go_display_choose;
  logic                      go_display_prompt;
  logic                      ld_node_index;
  logic                      go_judge_valid;
  logic                      go_display_invalid;
  logic [SEL_W-1:0]          prompt_sel;
  logic [NODE_W-1:0]         judge_index;
  logic [1:0]                invalid_code;
  logic [NUM_SEL*NODE_W-1:0] chosen_nodes;
  logic [RET_W-1:0]          retry_count;
  logic [3:0]                current_state;

  modport slave (
    input  start_process, go, input_over, data_reset_done, done_judge,
           node_index_valid, node_index_in,
    output end_process, abort_process, go_reset_data, go_display_choose,
           go_display_prompt, ld_node_index, go_judge_valid, go_display_invalid,
           prompt_sel, judge_index, invalid_code, chosen_nodes, retry_count,
           current_state
  );

  modport master (
    output start_process, go, input_over, data_reset_done, done_judge,
           node_index_valid, node_index_in,
    input  end_process, abort_process, go_reset_data, go_display_choose,
           go_display_prompt, ld_node_index, go_judge_valid, go_display_invalid,
           prompt_sel, judge_index, invalid_code, chosen_nodes, retry_count,
           current_state
  );

endinterface

// File: rtl/node_dup_check.sv
// Flags when the index under judgement equals one of the picks already stored
// for the current run (slots below prompt_sel only).
module node_dup_check
  import graph_ui_pkg::*;
#(
  parameter int NODE_W  = 4,
  parameter int NUM_SEL = 2
) (
  input  logic [NODE_W-1:0]          judge_index_i,
  input  logic [sel_width(NUM_SEL)-1:0] prompt_sel_i,
  input  logic [NUM_SEL*NODE_W-1:0]  chosen_nodes_i,
  output logic                       dup_o
);

  // Compare against every stored slot below the active selection.
  always_comb begin
    dup_o = 1'b0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if ((k < int'(prompt_sel_i)) &&
          (chosen_nodes_i[k*NODE_W +: NODE_W] == judge_index_i)) begin
        dup_o = 1'b1;
      end else begin
        dup_o = dup_o;
      end
    end
  end

endmodule

// File: rtl/choose_nodes_controller.sv
// Prompt / load / judge FSM that collects NUM_SEL validated node indices,
// with optional duplicate rejection and a per-pick retry limit.
module choose_nodes_controller
  import graph_ui_pkg::*;
#(
  parameter int NODE_W           = 4,
  parameter int NUM_SEL          = 2,
  parameter int MAX_RETRIES      = 3,
  parameter int REQUIRE_DISTINCT = 1
) (
  input  logic          clk,
  input  logic          program_reset,
  choose_nodes_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_SEL);
  localparam int RET_W = ret_width(MAX_RETRIES);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_SEL - 1);
  localparam logic [RET_W-1:0] RET_LIMIT = RET_W'(MAX_RETRIES);

  state_e                           state_q, state_d;
  logic [SEL_W-1:0]                 prompt_sel_q, prompt_sel_d;
  logic [RET_W-1:0]                 retry_q, retry_d, retry_inc;
  logic [1:0]                       code_q, code_d;
  logic [NODE_W-1:0]                judge_q, judge_d;
  logic [NUM_SEL-1:0][NODE_W-1:0]   chosen_q, chosen_d;
  strobes_t                         strb_q;
  logic                             dup_hit;

  node_dup_check #(.NODE_W(NODE_W), .NUM_SEL(NUM_SEL)) u_dup (
    .judge_index_i  (judge_q),
    .prompt_sel_i   (prompt_sel_q),
    .chosen_nodes_i (chosen_q),
    .dup_o          (dup_hit)
  );

  // Next-state and datapath update; retry_count bumps on the edge that enters INV.
  always_comb begin
    state_d      = state_q;
    prompt_sel_d = prompt_sel_q;
    retry_d      = retry_q;
    code_d       = code_q;
    judge_d      = judge_q;
    chosen_d     = chosen_q;
    retry_inc    = (&retry_q) ? retry_q : retry_q + RET_W'(1);
    case (state_q)
      ST_PRE:   if (bus.data_reset_done && bus.start_process) state_d = ST_DCH; else state_d = ST_PRE;
      ST_DCH:   if (bus.go) state_d = ST_DCH_W; else state_d = ST_DCH;
      ST_DCH_W: if (!bus.go) state_d = ST_DPR; else state_d = ST_DCH_W;
      ST_DPR:   if (bus.go) state_d = ST_DPR_W; else state_d = ST_DPR;
      ST_DPR_W: if (!bus.go) state_d = ST_LD; else state_d = ST_DPR_W;
      ST_LD:    if (bus.input_over) state_d = ST_LD_W; else state_d = ST_LD;
      ST_LD_W: begin
        if (!bus.input_over) begin
          state_d = ST_JDG;
          judge_d = bus.node_index_in;
        end else begin
          state_d = ST_LD_W;
        end
      end
      ST_JDG: begin
        if (bus.done_judge && bus.node_index_valid) begin
          state_d = ST_DUP;
        end else if (bus.done_judge) begin
          state_d = ST_INV;
          code_d  = INV_JUDGE;
          retry_d = retry_inc;
        end else begin
          state_d = ST_JDG;
        end
      end
      ST_DUP: begin
        if ((REQUIRE_DISTINCT != 0) && dup_hit) begin
          state_d = ST_INV;
          code_d  = INV_DUP;
          retry_d = retry_inc;
        end else begin
          state_d = ST_STO;
        end
      end
      ST_STO: begin
        chosen_d[prompt_sel_q] = judge_q;
        retry_d                = '0;
        if (prompt_sel_q == LAST_SEL) begin
          state_d = ST_DONE;
        end else begin
          state_d      = ST_DPR;
          prompt_sel_d = prompt_sel_q + SEL_W'(1);
        end
      end
      ST_INV: begin
        if ((MAX_RETRIES != 0) && (retry_q == RET_LIMIT)) state_d = ST_ABT;
        else if (bus.go)                                   state_d = ST_INV_W;
        else                                               state_d = ST_INV;
      end
      ST_INV_W: if (!bus.go) state_d = ST_DCH; else state_d = ST_INV_W;
      ST_DONE, ST_ABT: begin
        if (!bus.start_process) begin
          state_d      = ST_PRE;
          prompt_sel_d = '0;
          retry_d      = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_PRE;
    endcase
  end

  // State and datapath registers; strobes are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      state_q      <= ST_PRE;
      prompt_sel_q <= '0;
      retry_q      <= '0;
      code_q       <= INV_JUDGE;
      judge_q      <= '0;
      chosen_q     <= '0;
      strb_q       <= decode_strobes(ST_PRE);
    end else begin
      state_q      <= state_d;
      prompt_sel_q <= prompt_sel_d;
      retry_q      <= retry_d;
      code_q       <= code_d;
      judge_q      <= judge_d;
      chosen_q     <= chosen_d;
      strb_q       <= decode_strobes(state_d);
    end
  end

  assign bus.go_reset_data      = strb_q.go_reset_data;
  assign bus.go_display_choose  = strb_q.go_display_choose;
  assign bus.go_display_prompt  = strb_q.go_display_prompt;
  assign bus.ld_node_index      = strb_q.ld_node_index;
  assign bus.go_judge_valid     = strb_q.go_judge_valid;
  assign bus.go_display_invalid = strb_q.go_display_invalid;
  assign bus.end_process        = strb_q.end_process;
  assign bus.abort_process      = strb_q.abort_process;
  assign bus.prompt_sel         = prompt_sel_q;
  assign bus.judge_index        = judge_q;
  assign bus.invalid_code       = code_q;
  assign bus.chosen_nodes       = chosen_q;
  assign bus.retry_count        = retry_q;
  assign bus.current_state      = state_q;

endmodule

// File: tb/tb_choose_nodes_controller.sv
// Bench for choose_nodes_controller: three parameterisations share one stimulus
// driver; a pick-level reference model predicts every observable outcome.
module tb_choose_nodes_controller;

  localparam logic [7:0] S_NONE   = 8'h00;
  localparam logic [7:0] S_END    = 8'h80;
  localparam logic [7:0] S_ABORT  = 8'h40;
  localparam logic [7:0] S_RST    = 8'h20;
  localparam logic [7:0] S_CHOOSE = 8'h10;
  localparam logic [7:0] S_PROMPT = 8'h08;
  localparam logic [7:0] S_LD     = 8'h04;
  localparam logic [7:0] S_JUDGE  = 8'h02;
  localparam logic [7:0] S_INV    = 8'h01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, go, input_over, data_reset_done, done_judge, node_index_valid;
  logic [3:0] node_index_in;
  int         sel;
  int         tests_run = 0;
  int         fails = 0;

  int         cfg_num_sel, cfg_maxr;
  bit         cfg_distinct;
  logic [3:0] m_chosen[2];
  int         m_count, m_retries;
  bit         m_at_choose;

  choose_nodes_if #(.NODE_W(4), .NUM_SEL(2), .MAX_RETRIES(3)) if_a ();
  choose_nodes_if #(.NODE_W(4), .NUM_SEL(2), .MAX_RETRIES(0)) if_b ();
  choose_nodes_if #(.NODE_W(4), .NUM_SEL(1), .MAX_RETRIES(3)) if_c ();

  assign if_a.start_process = start && (sel == 0);
  assign if_b.start_process = start && (sel == 1);
  assign if_c.start_process = start && (sel == 2);
  assign if_a.go = go;  assign if_b.go = go;  assign if_c.go = go;
  assign if_a.input_over = input_over;  assign if_b.input_over = input_over;  assign if_c.input_over = input_over;
  assign if_a.data_reset_done = data_reset_done;  assign if_b.data_reset_done = data_reset_done;  assign if_c.data_reset_done = data_reset_done;
  assign if_a.done_judge = done_judge;  assign if_b.done_judge = done_judge;  assign if_c.done_judge = done_judge;
  assign if_a.node_index_valid = node_index_valid;  assign if_b.node_index_valid = node_index_valid;  assign if_c.node_index_valid = node_index_valid;
  assign if_a.node_index_in = node_index_in;  assign if_b.node_index_in = node_index_in;  assign if_c.node_index_in = node_index_in;

  choose_nodes_controller #(.NODE_W(4), .NUM_SEL(2), .MAX_RETRIES(3), .REQUIRE_DISTINCT(1)) dut_a (
    .clk(clk), .program_reset(rst), .bus(if_a.slave));
  choose_nodes_controller #(.NODE_W(4), .NUM_SEL(2), .MAX_RETRIES(0), .REQUIRE_DISTINCT(1)) dut_b (
    .clk(clk), .program_reset(rst), .bus(if_b.slave));
  choose_nodes_controller #(.NODE_W(4), .NUM_SEL(1), .MAX_RETRIES(3), .REQUIRE_DISTINCT(0)) dut_c (
    .clk(clk), .program_reset(rst), .bus(if_c.slave));

  logic [7:0] o_strb, o_chosen;
  logic [1:0] o_psel, o_code, o_retry;
  logic [3:0] o_jidx;

  always_comb begin
    o_strb   = {if_a.end_process, if_a.abort_process, if_a.go_reset_data, if_a.go_display_choose,
                if_a.go_display_prompt, if_a.ld_node_index, if_a.go_judge_valid, if_a.go_display_invalid};
    o_psel   = {1'b0, if_a.prompt_sel};
    o_code   = if_a.invalid_code;
    o_retry  = if_a.retry_count;
    o_jidx   = if_a.judge_index;
    o_chosen = if_a.chosen_nodes;
    case (sel)
      1: begin
        o_strb   = {if_b.end_process, if_b.abort_process, if_b.go_reset_data, if_b.go_display_choose,
                    if_b.go_display_prompt, if_b.ld_node_index, if_b.go_judge_valid, if_b.go_display_invalid};
        o_psel   = {1'b0, if_b.prompt_sel};
        o_code   = if_b.invalid_code;
        o_retry  = {1'b0, if_b.retry_count};
        o_jidx   = if_b.judge_index;
        o_chosen = if_b.chosen_nodes;
      end
      2: begin
        o_strb   = {if_c.end_process, if_c.abort_process, if_c.go_reset_data, if_c.go_display_choose,
                    if_c.go_display_prompt, if_c.ld_node_index, if_c.go_judge_valid, if_c.go_display_invalid};
        o_psel   = {1'b0, if_c.prompt_sel};
        o_code   = if_c.invalid_code;
        o_retry  = if_c.retry_count;
        o_jidx   = if_c.judge_index;
        o_chosen = {4'h0, if_c.chosen_nodes};
      end
      default: ;
    endcase
  end

  function automatic logic [7:0] exp_chosen();
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < cfg_num_sel; k++) r[k*4 +: 4] = m_chosen[k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_release();
    go = 1'b1; step();
    go = 1'b0; step();
  endtask

  task automatic do_reset(input int which);
    start = 1'b0; go = 1'b0; input_over = 1'b0; data_reset_done = 1'b0;
    done_judge = 1'b0; node_index_valid = 1'b0; node_index_in = 4'h0;
    sel = which;
    cfg_num_sel  = (which == 2) ? 1 : 2;
    cfg_maxr     = (which == 1) ? 0 : 3;
    cfg_distinct = (which != 2);
    rst = 1'b1; step();
    rst = 1'b0; step();
    m_chosen[0] = 4'h0; m_chosen[1] = 4'h0;
    m_count = 0; m_retries = 0; m_at_choose = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1; data_reset_done = 1'b1; step();
    tests_run++;
    if (o_strb !== S_CHOOSE) begin fails++; $display("FAIL session_start: strobes=%b expected %b", o_strb, S_CHOOSE); end
    m_at_choose = 1'b1;
  endtask

  task automatic end_session(input logic [7:0] final_strb);
    step();
    tests_run++;
    if (o_strb !== final_strb) begin fails++; $display("FAIL final_hold: strobes=%b expected %b", o_strb, final_strb); end
    start = 1'b0; step();
    m_count = 0; m_retries = 0;
    tests_run++;
    if (o_strb !== S_RST || o_psel !== 2'd0 || o_retry !== 2'd0 || o_chosen !== exp_chosen()) begin
      fails++;
      $display("FAIL back_to_pre: strobes=%b psel=%0d retry=%0d chosen=%h expected %b 0 0 %h",
               o_strb, o_psel, o_retry, o_chosen, S_RST, exp_chosen());
    end
  endtask

  // result: 0 stored (more to go), 1 done, 2 invalid, 3 aborted
  task automatic attempt(input logic [3:0] val, input bit verdict, output int result);
    bit is_dup;
    int exp_r;
    if (m_at_choose) begin
      tests_run++;
      if (o_strb !== S_CHOOSE) begin fails++; $display("FAIL at_choose: strobes=%b expected %b", o_strb, S_CHOOSE); end
      press_release();
    end
    tests_run++;
    if (o_strb !== S_PROMPT || o_psel !== 2'(m_count)) begin
      fails++; $display("FAIL prompt: strobes=%b psel=%0d expected %b %0d", o_strb, o_psel, S_PROMPT, m_count);
    end
    press_release();
    tests_run++;
    if (o_strb !== S_LD) begin fails++; $display("FAIL load: strobes=%b expected %b", o_strb, S_LD); end
    node_index_in = val; input_over = 1'b1; step();
    input_over = 1'b0; step();
    node_index_in = ~val;
    tests_run++;
    if (o_strb !== S_JUDGE || o_jidx !== val) begin
      fails++; $display("FAIL judge_latch: strobes=%b idx=%h expected %b %h", o_strb, o_jidx, S_JUDGE, val);
    end
    repeat ($urandom_range(0, 3)) step();
    tests_run++;
    if (o_strb !== S_JUDGE) begin fails++; $display("FAIL judge_hold: strobes=%b expected %b", o_strb, S_JUDGE); end
    done_judge = 1'b1; node_index_valid = verdict; step();
    done_judge = 1'b0; node_index_valid = 1'b0;
    is_dup = 1'b0;
    for (int k = 0; k < m_count; k++) if (cfg_distinct && m_chosen[k] == val) is_dup = 1'b1;
    if (verdict) begin
      tests_run++;
      if (o_strb !== S_NONE) begin fails++; $display("FAIL dup_stage: strobes=%b expected %b", o_strb, S_NONE); end
      step();
      if (!is_dup) begin
        tests_run++;
        if (o_strb !== S_NONE) begin fails++; $display("FAIL store_stage: strobes=%b expected %b", o_strb, S_NONE); end
        step();
      end
    end
    if (!verdict || is_dup) begin
      m_retries++;
      exp_r = (cfg_maxr == 0) ? 1 : m_retries;
      tests_run++;
      if (o_strb !== S_INV || o_code !== (verdict ? 2'd1 : 2'd0) || o_retry !== 2'(exp_r)) begin
        fails++; $display("FAIL invalid: strobes=%b code=%0d retry=%0d expected %b %0d %0d",
                          o_strb, o_code, o_retry, S_INV, verdict ? 1 : 0, exp_r);
      end
      if (cfg_maxr != 0 && m_retries == cfg_maxr) begin
        step();
        tests_run++;
        if (o_strb !== S_ABORT) begin fails++; $display("FAIL abort: strobes=%b expected %b", o_strb, S_ABORT); end
        result = 3;
      end else begin
        press_release();
        m_at_choose = 1'b1;
        result = 2;
      end
    end else begin
      m_chosen[m_count] = val;
      m_count++;
      m_retries = 0;
      m_at_choose = 1'b0;
      tests_run++;
      if (o_chosen !== exp_chosen() || o_retry !== 2'd0) begin
        fails++; $display("FAIL store: chosen=%h retry=%0d expected %h 0", o_chosen, o_retry, exp_chosen());
      end
      result = (m_count == cfg_num_sel) ? 1 : 0;
      tests_run++;
      if (o_strb !== ((result == 1) ? S_END : S_PROMPT)) begin
        fails++; $display("FAIL after_store: strobes=%b expected %b", o_strb, (result == 1) ? S_END : S_PROMPT);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(0);
    rst = 1'b1; #1;
    tests_run++;
    if (o_strb !== S_RST || o_chosen !== 8'h00 || o_jidx !== 4'h0 || o_psel !== 2'd0 ||
        o_retry !== 2'd0 || o_code !== 2'd0) begin
      fails++; $display("FAIL reset_values: strobes=%b chosen=%h idx=%h psel=%0d retry=%0d code=%0d expected %b all zero",
                        o_strb, o_chosen, o_jidx, o_psel, o_retry, o_code, S_RST);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_basic();
    int r;
    do_reset(0);
    begin_session();
    attempt(4'h3, 1'b1, r);
    attempt(4'h5, 1'b1, r);
    tests_run++;
    if (r !== 1 || o_chosen !== 8'h53) begin fails++; $display("FAIL basic: result=%0d chosen=%h expected 1 53", r, o_chosen); end
    end_session(S_END);
  endtask

  task automatic test_duplicate();
    int r;
    do_reset(0);
    begin_session();
    attempt(4'h3, 1'b1, r);
    attempt(4'h3, 1'b1, r);
    tests_run++;
    if (r !== 2 || o_code !== 2'd1 || o_retry !== 2'd1 || o_psel !== 2'd1 || o_strb !== S_CHOOSE) begin
      fails++; $display("FAIL duplicate: result=%0d code=%0d retry=%0d psel=%0d strobes=%b expected 2 1 1 1 %b",
                        r, o_code, o_retry, o_psel, o_strb, S_CHOOSE);
    end
    attempt(4'h7, 1'b1, r);
    tests_run++;
    if (o_chosen !== 8'h73) begin fails++; $display("FAIL dup_final: chosen=%h expected 73", o_chosen); end
    end_session(S_END);
  endtask

  task automatic test_abort();
    int r;
    do_reset(0);
    begin_session();
    for (int i = 0; i < 3; i++) attempt(4'(i + 2), 1'b0, r);
    tests_run++;
    if (r !== 3) begin fails++; $display("FAIL abort_result: result=%0d expected 3", r); end
    end_session(S_ABORT);
  endtask

  task automatic test_unlimited();
    int r;
    do_reset(1);
    begin_session();
    for (int i = 0; i < 20; i++) attempt(4'($urandom_range(0, 15)), 1'b0, r);
    tests_run++;
    if (r !== 2 || o_retry !== 2'd1 || o_strb !== S_CHOOSE) begin
      fails++; $display("FAIL unlimited: result=%0d retry=%0d strobes=%b expected 2 1 %b", r, o_retry, o_strb, S_CHOOSE);
    end
    attempt(4'h4, 1'b1, r);
    attempt(4'h6, 1'b1, r);
    tests_run++;
    if (r !== 1 || o_chosen !== 8'h64) begin fails++; $display("FAIL unlimited_done: result=%0d chosen=%h expected 1 64", r, o_chosen); end
    end_session(S_END);
  endtask

  task automatic test_reset_mid_judge();
    int r;
    do_reset(0);
    begin_session();
    attempt(4'hA, 1'b1, r);
    attempt(4'hB, 1'b1, r);
    end_session(S_END);
    begin_session();
    press_release();
    press_release();
    node_index_in = 4'hC; input_over = 1'b1; step();
    input_over = 1'b0; step();
    done_judge = 1'b1; node_index_valid = 1'b1;
    #2 rst = 1'b1; #1;
    tests_run++;
    if (o_strb !== S_RST || o_chosen !== 8'h00 || o_jidx !== 4'h0 || o_psel !== 2'd0 || o_retry !== 2'd0) begin
      fails++; $display("FAIL reset_mid_judge: strobes=%b chosen=%h idx=%h psel=%0d retry=%0d expected %b zeros",
                        o_strb, o_chosen, o_jidx, o_psel, o_retry, S_RST);
    end
    step();
    tests_run++;
    if (o_strb !== S_RST) begin fails++; $display("FAIL reset_hold: strobes=%b expected %b", o_strb, S_RST); end
    done_judge = 1'b0; node_index_valid = 1'b0; start = 1'b0;
    rst = 1'b0; step();
  endtask

  task automatic test_single();
    int r;
    do_reset(2);
    begin_session();
    attempt(4'h9, 1'b1, r);
    tests_run++;
    if (r !== 1 || o_chosen !== 8'h09) begin fails++; $display("FAIL single: result=%0d chosen=%h expected 1 09", r, o_chosen); end
    end_session(S_END);
  endtask

  task automatic test_random();
    int r;
    logic [3:0] v;
    for (int s = 0; s < 8; s++) begin
      if (s == 0 || s == 5) do_reset((s == 0) ? 0 : 1);
      begin_session();
      r = 0;
      for (int a = 0; a < 30 && r != 1 && r != 3; a++) begin
        if (m_count > 0 && $urandom_range(0, 2) == 0) v = m_chosen[0];
        else v = 4'($urandom_range(0, 15));
        attempt(v, $urandom_range(0, 3) != 0, r);
      end
      if (r == 1) end_session(S_END);
      else if (r == 3) end_session(S_ABORT);
      else do_reset(sel);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_duplicate();
    test_abort();
    test_unlimited();
    test_reset_mid_judge();
    test_single();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
